// File: rtl/harvard_bus_pkg.sv
// Shared types and sizing helpers for the Harvard-to-single-bus bridge.
// Imported by the bridge top and its transaction timer.
package harvard_bus_pkg;

    typedef enum logic [2:0] {
        INIT,
        FETCH,
        DREAD,
        DWRITE,
        STEP,
        HALT
    } bridge_state_t;

    localparam logic [3:0] BYTEEN_ALL_DEFAULT = 4'b1111;

    function automatic int timer_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/bus_txn_timer.sv
// Stall-cycle counter for one bus transaction.
// Flags the stalled cycle that brings the count up to LIMIT.
module bus_txn_timer
    import harvard_bus_pkg::*;
#(
    parameter int LIMIT = 1024,
    parameter int W     = timer_width(LIMIT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    generate
        if (LIMIT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = count_en && !clear
                          && (count == W'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/harvard_bus_bridge.sv
// Serialises each CPU step into fetch / data read / data write bus cycles
// and gates the CPU clock so it advances once per completed step.
module harvard_bus_bridge
    import harvard_bus_pkg::*;
#(
    parameter int         BUS_TIMEOUT = 1024,
    parameter logic [3:0] BYTEEN_ALL  = BYTEEN_ALL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    output logic        cpu_clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        bus_error
);

    bridge_state_t state, state_n;
    logic        decode, decode_n;
    logic        rd_n, wr_n, err_n;
    logic [31:0] addr_n, wdata_n, ir_n, dr_n;
    logic        txn_start;
    logic        expired;

    bus_txn_timer #(.LIMIT(BUS_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (txn_start),
        .count_en ((bus_read | bus_write) & bus_waitrequest),
        .expired  (expired)
    );

    assign cpu_clk_enable = (state == INIT) || (state == STEP);
    assign bus_byteenable = BYTEEN_ALL;

    always_comb begin
        state_n   = state;
        decode_n  = decode;
        rd_n      = bus_read;
        wr_n      = bus_write;
        addr_n    = bus_address;
        wdata_n   = bus_writedata;
        ir_n      = instr_readdata;
        dr_n      = data_readdata;
        err_n     = bus_error;
        txn_start = 1'b0;
        unique case (state)
            INIT: state_n = FETCH;
            FETCH: begin
                // decode cycle: CPU request lines now reflect the new word
                if (decode) begin
                    decode_n = 1'b0;
                    if (data_read)       state_n = DREAD;
                    else if (data_write) state_n = DWRITE;
                    else                 state_n = STEP;
                end else if (!bus_read) begin
                    if (!cpu_active) begin
                        state_n = HALT;
                    end else begin
                        rd_n      = 1'b1;
                        addr_n    = instr_address;
                        txn_start = 1'b1;
                    end
                end else if (!bus_waitrequest) begin
                    rd_n     = 1'b0;
                    ir_n     = bus_readdata;
                    decode_n = 1'b1;
                end
            end
            DREAD: begin
                if (!bus_read) begin
                    rd_n      = 1'b1;
                    addr_n    = data_address;
                    txn_start = 1'b1;
                end else if (!bus_waitrequest) begin
                    rd_n    = 1'b0;
                    dr_n    = bus_readdata;
                    state_n = data_write ? DWRITE : STEP;
                end
            end
            DWRITE: begin
                if (!bus_write) begin
                    wr_n      = 1'b1;
                    addr_n    = data_address;
                    wdata_n   = data_writedata;
                    txn_start = 1'b1;
                end else if (!bus_waitrequest) begin
                    wr_n    = 1'b0;
                    state_n = STEP;
                end
            end
            STEP: state_n = FETCH;
            HALT: state_n = HALT;
            default: state_n = HALT;
        endcase
        if (expired) begin
            err_n    = 1'b1;
            rd_n     = 1'b0;
            wr_n     = 1'b0;
            decode_n = 1'b0;
            state_n  = HALT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= INIT;
            decode         <= 1'b0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_address    <= '0;
            bus_writedata  <= '0;
            instr_readdata <= '0;
            data_readdata  <= '0;
            bus_error      <= 1'b0;
        end else begin
            state          <= state_n;
            decode         <= decode_n;
            bus_read       <= rd_n;
            bus_write      <= wr_n;
            bus_address    <= addr_n;
            bus_writedata  <= wdata_n;
            instr_readdata <= ir_n;
            data_readdata  <= dr_n;
            bus_error      <= err_n;
        end
    end

endmodule

// File: tb/tb_harvard_bus_bridge.sv
// Bench for harvard_bus_bridge: toy CPU, randomised-stall slave memory
// and a per-step scoreboard of the bus transactions each step must produce.
module tb_harvard_bus_bridge;

    localparam int TMO = 8;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_active;
    logic        cpu_clk_enable;
    logic [31:0] instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_read, data_write;
    logic [31:0] bus_address, bus_writedata, bus_readdata;
    logic        bus_read, bus_write, bus_waitrequest, bus_error;
    logic [3:0]  bus_byteenable;

    always #5 clk = ~clk;

    harvard_bus_bridge #(.BUS_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_active      (cpu_active),
        .cpu_clk_enable  (cpu_clk_enable),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .bus_address     (bus_address),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_writedata   (bus_writedata),
        .bus_byteenable  (bus_byteenable),
        .bus_waitrequest (bus_waitrequest),
        .bus_readdata    (bus_readdata),
        .bus_error       (bus_error)
    );

    // Toy CPU: request lines decoded from the presented instruction word.
    logic [31:0] pc;
    assign instr_address  = pc;
    assign data_read      = instr_readdata[31];
    assign data_write     = instr_readdata[30];
    assign data_address   = 32'h1000 | {22'h0, instr_readdata[9:2], 2'b00};
    assign data_writedata = ~instr_readdata;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         log_q[$];
    logic [31:0] mem [logic [31:0]];
    int          total = 0;
    int          passed = 0;
    bit          mon_en = 0;
    bit          in_txn = 0;
    bit          t_wr;
    bit          stall_all = 0;
    logic [31:0] t_addr, t_data, dprev;
    int          wleft, chosen, hi_cyc, stall_cnt;
    int          force_wait = -1;
    int          strobe_cyc = 0;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a * 32'h9E37_79B1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Slave and monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_read || bus_write) strobe_cyc++;
            if (in_txn && !bus_waitrequest) begin
                check("strobe_drop", {62'd0, bus_read, bus_write}, 64'd0);
                check("hi_cycles", 64'(hi_cyc), 64'(chosen + 1));
                if (t_wr) mem[t_addr] = t_data;
                log_q.push_back('{t_wr ? 1 : 0, t_addr, t_data});
                in_txn = 0;
            end else if (in_txn && bus_error) begin
                in_txn = 0;
            end
            if (cpu_clk_enable)
                log_q.push_back('{2, data_readdata, instr_readdata});
            if (!in_txn && (bus_read || bus_write)) begin
                in_txn = 1;
                t_wr   = bus_write;
                t_addr = bus_address;
                t_data = bus_writedata;
                hi_cyc = 0;
                stall_cnt = 0;
                chosen = (force_wait >= 0) ? force_wait
                                           : int'($urandom_range(0, 4));
                wleft  = chosen;
            end
            if (in_txn) begin
                check("hold", {30'd0, bus_read, bus_write, bus_address},
                      {30'd0, !t_wr, t_wr, t_addr});
                if (t_wr) check("wdata_hold", {32'd0, bus_writedata},
                                {32'd0, t_data});
                check("byteen", {60'd0, bus_byteenable}, 64'hF);
                hi_cyc++;
                if (stall_all || wleft > 0) begin
                    bus_waitrequest = 1'b1;
                    bus_readdata    = $urandom;
                    stall_cnt++;
                    if (wleft > 0) wleft--;
                end else begin
                    bus_waitrequest = 1'b0;
                    bus_readdata    = memrd(t_addr);
                end
            end else begin
                bus_waitrequest = 1'($urandom_range(0, 1));
                bus_readdata    = $urandom;
            end
        end
    end

    task automatic hold_reset();
        reset  = 1'b0;
        mon_en = 0;
        in_txn = 0;
        log_q.delete();
        pc     = RESET_PC;
        dprev  = 32'h0;
        stall_all  = 0;
        force_wait = -1;
        bus_waitrequest = 1'b1;
        bus_readdata    = 32'h0;
    endtask

    task automatic release_reset();
        ev_t e;
        int  g;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1;
        g = 0;
        while (log_q.size() < 1 && g < 20) begin
            tick();
            g++;
        end
        check("init_seen", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) begin
            e = log_q.pop_front();
            check("init_kind", 64'(e.kind), 64'd2);
            check("init_ir", {32'd0, e.data}, 64'd0);
        end
    endtask

    task automatic do_step(input logic [31:0] w, input int fw);
        ev_t         exp_q[$];
        ev_t         e;
        logic [31:0] da, drx;
        int          g;
        mem[pc]    = w;
        force_wait = fw;
        da  = 32'h1000 | {22'h0, w[9:2], 2'b00};
        drx = w[31] ? memrd(da) : dprev;
        exp_q.push_back('{0, pc, 32'h0});
        if (w[31]) exp_q.push_back('{0, da, 32'h0});
        if (w[30]) exp_q.push_back('{1, da, ~w});
        exp_q.push_back('{2, drx, w});
        g = 0;
        while (log_q.size() < exp_q.size() && g < 200) begin
            tick();
            g++;
        end
        check("step_done", 64'(log_q.size() >= exp_q.size()), 64'd1);
        foreach (exp_q[i]) begin
            if (log_q.size() > 0) begin
                e = log_q.pop_front();
                check($sformatf("kind%0d", i), 64'(e.kind),
                      64'(exp_q[i].kind));
                check($sformatf("addr%0d", i), {32'd0, e.addr},
                      {32'd0, exp_q[i].addr});
                if (exp_q[i].kind != 0)
                    check($sformatf("data%0d", i), {32'd0, e.data},
                          {32'd0, exp_q[i].data});
            end
        end
        pc    = pc + 32'd4;
        dprev = drx;
    endtask

    initial begin
        int base, g;
        cpu_active = 1'b1;
        hold_reset();
        repeat (3) tick();
        check("rst_en", {63'd0, cpu_clk_enable}, 64'd1);
        check("rst_strobes", {62'd0, bus_read, bus_write}, 64'd0);
        check("rst_addr", {32'd0, bus_address}, 64'd0);
        check("rst_wdata", {32'd0, bus_writedata}, 64'd0);
        check("rst_rdata", {instr_readdata, data_readdata}, 64'd0);
        check("rst_err", {63'd0, bus_error}, 64'd0);
        release_reset();

        do_step(32'h2408_0005, 0);
        mem[32'h1000] = 32'hDEAD_BEEF;
        do_step(32'h8C00_0000, 3);
        check("lw_data", {32'd0, data_readdata}, 64'hDEAD_BEEF);
        do_step(32'hC000_0010, 2);
        for (int i = 0; i < 40; i++) do_step($urandom, -1);

        cpu_active = 1'b0;
        base = strobe_cyc;
        repeat (20) tick();
        check("halt_strobes", 64'(strobe_cyc - base), 64'd0);
        check("halt_log", 64'(log_q.size()), 64'd0);
        check("halt_en", {63'd0, cpu_clk_enable}, 64'd0);

        hold_reset();
        cpu_active = 1'b1;
        repeat (2) tick();
        release_reset();
        do_step($urandom, -1);
        stall_all = 1;
        mem[pc] = 32'h0;
        g = 0;
        while (!bus_error && g < 50) begin
            tick();
            g++;
        end
        check("tmo_err", {63'd0, bus_error}, 64'd1);
        check("tmo_stalls", 64'(stall_cnt), 64'(TMO));
        check("tmo_strobes", {62'd0, bus_read, bus_write}, 64'd0);
        check("tmo_en", {63'd0, cpu_clk_enable}, 64'd0);
        base = strobe_cyc;
        repeat (10) tick();
        check("tmo_quiet", 64'(strobe_cyc - base), 64'd0);
        check("tmo_sticky", {62'd0, bus_error, cpu_clk_enable}, 64'd2);

        hold_reset();
        repeat (2) tick();
        release_reset();
        check("err_cleared", {63'd0, bus_error}, 64'd0);
        do_step(32'hC000_0024, -1);
        mem[pc] = 32'hC000_0020;
        force_wait = 5;
        g = 0;
        while (!(bus_write && bus_waitrequest) && g < 100) begin
            tick();
            g++;
        end
        check("dwrite_seen", {63'd0, bus_write}, 64'd1);
        #1;
        hold_reset();
        #1;
        check("async_write", {62'd0, bus_write, bus_read}, 64'd0);
        check("async_en", {63'd0, cpu_clk_enable}, 64'd1);
        check("async_addr", {32'd0, bus_address}, 64'd0);
        repeat (2) tick();
        release_reset();
        do_step(32'h2408_0001, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/harvard_bus_bridge.md
Name: harvard_bus_bridge

Overview:
- Sits between mips_cpu_harvard and a single shared memory bus with a read/write/waitrequest handshake.
- Serialises each CPU clock step into an instruction fetch, an optional data read and an optional data write on the bus.
- Returns latched read data to the CPU's combinational read ports.
- Drives the CPU clk_enable, so the CPU advances exactly one clock per completed step.

Parameters:
BUS_TIMEOUT, 1024, max cycles waitrequest may stay high for one transaction; 0 disables the timeout
BYTEEN_ALL, 4'b1111, byteenable driven on every transaction (the CPU does read-modify-write for partial stores)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cpu_active  input  1  CPU active output
cpu_clk_enable  output  1  drives the CPU clk_enable
instr_address  input  32  CPU fetch address
instr_readdata  output  32  latched instruction word
data_address  input  32  CPU data address (word aligned)
data_read  input  1  CPU data read request
data_write  input  1  CPU data write request
data_writedata  input  32  CPU store word
data_readdata  output  32  latched data word
bus_address  output  32  bus address
bus_read  output  1  bus read strobe
bus_write  output  1  bus write strobe
bus_writedata  output  32  bus write data
bus_byteenable  output  4  always BYTEEN_ALL
bus_waitrequest  input  1  slave stall
bus_readdata  input  32  slave read data, valid in the cycle waitrequest is low
bus_error  output  1  sticky timeout flag

Behaviour:
- States: INIT, FETCH, DREAD, DWRITE, STEP, HALT.
- Reset asserted (async):
  - state=INIT, cpu_clk_enable=1 (so the CPU's synchronous reset takes effect while reset is held).
  - bus_read=0, bus_write=0, bus_address=0, bus_writedata=0.
  - instr_readdata=0, data_readdata=0, bus_error=0, timer=0.
- INIT: cpu_clk_enable=1 for one cycle after reset release, then go to FETCH.
- FETCH:
  - If cpu_active=0, go to HALT without starting a bus cycle.
  - Otherwise drive bus_read=1 and bus_address=instr_address.
  - In the cycle bus_waitrequest=0: latch bus_readdata into instr_readdata.
  - Next state: DREAD if data_read; else DWRITE if data_write; else STEP.
  - The choice uses the CPU request lines as they are once the new instruction word is presented, i.e. evaluated in the cycle after the latch. Implement this as a one-cycle decode sub-phase inside FETCH.
- DREAD:
  - bus_read=1, bus_address=data_address.
  - On waitrequest=0: latch data_readdata, then go to DWRITE if data_write, else STEP.
- DWRITE:
  - bus_write=1, bus_address=data_address, bus_writedata=data_writedata.
  - Hold all of these stable while waitrequest=1.
  - On waitrequest=0, go to STEP.
- STEP: cpu_clk_enable=1 for exactly one cycle, then FETCH. cpu_clk_enable=0 in every other non-INIT state.
- HALT: no bus activity, cpu_clk_enable=0. Leave only by reset.
- Strobes:
  - bus_read and bus_write are never both high.
  - Strobes are registered and deassert in the cycle after the one in which waitrequest=0.
- Timeout:
  - The timer counts cycles with a strobe high and waitrequest=1; it clears on every new transaction.
  - If BUS_TIMEOUT != 0 and timer reaches BUS_TIMEOUT: set bus_error=1 (sticky), drop the strobes, go to HALT.
- Latched words change only on a completed read.
- An instruction refetch on each step is required; there is no caching.

Decomposition:
- Package harvard_bus_pkg holds:
  - bridge_state_t enum (INIT, FETCH, DREAD, DWRITE, STEP, HALT)
  - BYTEEN_ALL default
  - the timer width, which is clog2(BUS_TIMEOUT+1) when BUS_TIMEOUT > 0 and 1 otherwise
- One sub-module, bus_txn_timer:
  - clear, count enable, terminal-count output
  - inputs clk and active-low async reset

Test Plan:
1. Zero-wait slave, instr at 0xBFC00000 is addiu (no memory access) -> per step: FETCH (1 bus read at 0xBFC00000), STEP with clk_enable=1 for 1 cycle; data bus lines idle.
2. lw with waitrequest held 3 cycles per transaction, memory[0x1000]=0xDEADBEEF -> instr read, then read at 0x1000 held for 4 cycles, data_readdata=0xDEADBEEF before the clk_enable pulse.
3. sb exec step with data_read and data_write both high -> DREAD then DWRITE at the same address, bus_writedata stable through 2 wait cycles, then a single STEP pulse.
4. BUS_TIMEOUT=8, slave never deasserts waitrequest -> bus_error=1 after 8 stalled cycles, strobes low, clk_enable stays 0, state HALT.
5. cpu_active drops after a jr to 0 -> next FETCH enters HALT, no further bus_read.
6. reset pulled low mid-DWRITE -> bus_write drops immediately (async), cpu_clk_enable=1; after release exactly one INIT enable cycle, then a fetch at 0xBFC00000.
